// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver, 3-sample majority vote, valid/ready holding register.
// Optional break detection is compiled in when UART_RX_BREAK_DET_EN is defined.
module uart_rx_param #(
  parameter int CLKS_FREQ = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  output logic                 rx_break
);

  localparam int CPB  = CLKS_FREQ / BAUD_RATE;
  localparam int HALF = (CPB - 1) / 2;
  localparam int CW   = $clog2(CPB) + 1;
  localparam int IW   = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_HALF  = CW'(HALF);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);

  if (CPB < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
    $error("uart_rx_param: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT
  } state_t;

  state_t               state;
  logic [1:0]           sync;
  logic [2:0]           hist;
  logic                 rx_s;
  logic                 maj;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr;
  logic                 perr;
  logic                 tick;
  logic                 accept;
  logic                 brk_now;

  assign rx_s   = sync[1];
  assign maj    = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
  assign tick   = (cnt == CNT_LAST);
  assign accept = !rx_valid || rx_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= 2'b11;
      hist <= 3'b111;
    end else begin
      sync <= {sync[0], rx};
      hist <= {hist[1:0], rx_s};
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  // Stays set only while every sampled bit of the frame has been low.
  logic all_low;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      all_low <= 1'b0;
    end else if (state == S_START) begin
      all_low <= 1'b1;
    end else if (tick && maj &&
                 (state == S_DATA || state == S_PARITY || state == S_STOP)) begin
      all_low <= 1'b0;
    end
  end

  assign brk_now = all_low & ~maj;
`else
  assign brk_now = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      stop_idx      <= 1'b0;
      shreg         <= '0;
      ferr          <= 1'b0;
      perr          <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
      rx_break      <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      rx_break   <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      unique case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            ferr     <= 1'b0;
            perr     <= 1'b0;
            state    <= maj ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tick) begin
            cnt   <= '0;
            shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (bit_idx == IDX_LAST) begin
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (tick) begin
            cnt   <= '0;
            perr  <= ((^shreg) ^ maj) != PAR_ODD;
            state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tick) begin
            cnt <= '0;
            if (!maj) begin
              ferr <= 1'b1;
            end
            if (stop_idx == STOP_LAST) begin
              if (brk_now) begin
                rx_break <= 1'b1;
                state    <= S_WAIT;
              end else begin
                if (accept) begin
                  rx_valid      <= 1'b1;
                  rx_data       <= shreg;
                  rx_frame_err  <= ferr | ~maj;
                  rx_parity_err <= perr;
                end else begin
                  rx_overrun <= 1'b1;
                end
                state <= maj ? S_IDLE : S_WAIT;
              end
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          // A stuck-low line must go high before a new start is accepted.
          if (rx_s) begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
